// File: rtl/sra_iter_pkg.sv
// -----------------------------------------------------------------------------
// sra_iter_pkg
// Shared definitions for the iterative 32-bit right shifter (sra_iter).
//   - state_t     : FSM state encoding (IDLE / SHIFT / DONE)
//   - WIDTH       : datapath width (32)
//   - STAGES      : number of shift stages (5)
//   - STAGE_K     : shift distance per stage, applied in order {16,8,4,2,1}
//   - stage_width : looks up the shift distance for a stage index
// -----------------------------------------------------------------------------
package sra_iter_pkg;

    localparam int WIDTH  = 32;
    localparam int STAGES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Stage cnt shifts by STAGE_K[cnt] when shamt bit (4-cnt) is set.
    localparam logic [4:0] STAGE_K [STAGES] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

    // Indices beyond the table return 0 (no shift) so an illegal counter value
    // can never corrupt the accumulator.
    function automatic logic [4:0] stage_width(input logic [2:0] idx);
        logic [4:0] k;
        k = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (idx == 3'(i)) begin
                k = STAGE_K[i];
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/sr_stage.sv
// -----------------------------------------------------------------------------
// sr_stage
// Combinational single right-shift stage, reused by sra_iter on every SHIFT
// cycle. The shift distance is selected from the package table by cnt.
// Ports:
//   acc     in  32  word to shift
//   cnt     in  3   stage index (0..4 -> shift by 16/8/4/2/1)
//   enable  in  1   1 = apply this stage, 0 = pass acc through
//   fill    in  1   bit shifted into the vacated upper positions
//   shifted out 32  result
// -----------------------------------------------------------------------------
module sr_stage
    import sra_iter_pkg::*;
(
    input  logic [WIDTH-1:0] acc,
    input  logic [2:0]       cnt,
    input  logic             enable,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] ext_shifted;
    logic [4:0]            k;

    // Prepending the fill bit and shifting arithmetically replicates fill into
    // the top k positions, covering both logical (fill=0) and arithmetic cases.
    // NOTE: every always_comb output gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        k           = stage_width(cnt);
        ext         = {fill, acc};
        ext_shifted = ext >>> k;
        shifted     = acc;
        if (enable) begin
            shifted = ext_shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sra_iter.sv
// -----------------------------------------------------------------------------
// sra_iter
// Iterative 32-bit logical/arithmetic right shifter. A request is accepted in
// IDLE or DONE, then one stage (16/8/4/2/1) is applied per clock in SHIFT. The
// result appears on out together with a one-cycle done pulse and holds until
// the next completion.
//
// Build option:
//   SRA_ITER_EARLY_EXIT_EN - leave SHIFT as soon as no remaining shamt bits
//                            are set (shamt=0 completes straight from accept).
//                            Results are identical; only latency changes.
//
// Ports:
//   clock  in  1   rising-edge clock
//   reset  in  1   asynchronous active-high reset
//   start  in  1   request strobe (accepted only when busy=0)
//   in     in  32  operand, captured on acceptance
//   shamt  in  5   shift amount, captured on acceptance
//   arith  in  1   1 = arithmetic (sign fill), 0 = logical (zero fill)
//   out    out 32  result register
//   busy   out 1   high while shifting; requests ignored
//   done   out 1   one-cycle completion pulse
// -----------------------------------------------------------------------------
module sra_iter
    import sra_iter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [4:0]       shamt,
    input  logic             arith,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

`ifdef SRA_ITER_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_shifted;
    logic [4:0]       amt;
    logic             fill;
    logic [2:0]       cnt;

    logic             accept;
    logic             accept_zero;
    logic             stage_en;
    logic             stage_last;
    logic [4:0]       amt_aligned;
    logic [4:0]       amt_rest;

    // Left-aligning amt by cnt puts the bit for the current stage at [4] and
    // the bits of all later stages below it.
    assign amt_aligned = amt << cnt;
    assign stage_en    = amt_aligned[4];
    assign amt_rest    = amt_aligned << 1;

    assign stage_last  = (cnt == 3'(STAGES - 1)) || (EARLY_EXIT && (amt_rest == '0));
    assign accept_zero = EARLY_EXIT && (shamt == '0);

    sr_stage u_stage (
        .acc     (acc),
        .cnt     (cnt),
        .enable  (stage_en),
        .fill    (fill),
        .shifted (acc_shifted)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = accept_zero ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (stage_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = accept_zero ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // out is written only on the edge that enters DONE, so intermediate
    // accumulator values are never visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            amt  <= '0;
            fill <= 1'b0;
            cnt  <= '0;
            out  <= '0;
        end else if (accept) begin
            acc  <= in;
            amt  <= shamt;
            fill <= arith & in[WIDTH-1];
            cnt  <= '0;
            if (accept_zero) begin
                out <= in;
            end
        end else if (state == SHIFT) begin
            acc <= acc_shifted;
            cnt <= cnt + 3'd1;
            if (stage_last) begin
                out <= acc_shifted;
            end
        end
    end

endmodule

// File: tb/tb_sra_iter.sv
// -----------------------------------------------------------------------------
// tb_sra_iter
// Self-checking bench for sra_iter. A behavioural model computes each result
// with the language shift operators and tracks completion latency as a simple
// edge countdown; a compare process checks busy/done/out against it on every
// falling edge outside reset. Directed requests additionally check literal
// hand-computed results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sra_iter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] din   = '0;
    logic [4:0]  shamt = '0;
    logic        arith = 1'b0;
    logic [31:0] dout;
    logic        busy;
    logic        done;

    int n_checks   = 0;
    int n_fail     = 0;
    int cycle      = 0;
    int done_count = 0;

    sra_iter dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .in    (din),
        .shamt (shamt),
        .arith (arith),
        .out   (dout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    always @(negedge clock) begin
        if (!reset && done) done_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] s, input logic a);
        logic signed [31:0] sv;
        sv = v;
        return a ? 32'(sv >>> s) : (v >> s);
    endfunction

    // Edges after the accepting edge until done is visible.
    function automatic int ref_latency(input logic [4:0] s);
        int r;
`ifdef SRA_ITER_EARLY_EXIT_EN
        r = 0;
        for (int b = 4; b >= 0; b--) begin
            if (s[b]) r = 5 - b;
        end
`else
        r = 5;
`endif
        return r;
    endfunction

    logic [31:0] m_out  = '0;
    logic [31:0] m_res  = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_out  = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_out  = m_res;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_res  = ref_shift(din, shamt, arith);
                m_left = ref_latency(shamt);
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_out  = m_res;
                end else begin
                    m_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_done", 32'(done), 32'(m_done));
            check("model_out",  dout,      m_out);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called away from a clock edge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [31:0] v, input logic [4:0] s, input logic a);
        start = 1'b1;
        din   = v;
        shamt = s;
        arith = a;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Returns the index of the falling edge (0 = first after the call) where
    // done was seen, or -1 after the cycle budget expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic run(input string name, input logic [31:0] v, input logic [4:0] s,
                       input logic a, input logic [31:0] exp);
        int lat;
        issue(v, s, a);
        wait_done(lat);
        check(name, dout, exp);
        check({name, "_latency"}, 32'(lat), 32'(ref_latency(s)));
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed test ----------------
    initial begin
        int lat;
        int d0;
        int c1;
        int c2;

        #2;
        check("reset_out",  dout,      32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;

        run("srl_8",      32'h8000_0000, 5'd8,  1'b0, 32'h0080_0000);
        run("sra_8_neg",  32'h8000_0000, 5'd8,  1'b1, 32'hFF80_0000);
        run("sra_8_pos",  32'h4000_0000, 5'd8,  1'b1, 32'h0040_0000);
        run("sra_31",     32'h8000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF);
        run("srl_31",     32'h8000_0001, 5'd31, 1'b0, 32'h0000_0001);
        run("shamt_0",    32'hA5A5_A5A5, 5'd0,  1'b1, 32'hA5A5_A5A5);
        run("sra_16",     32'h8765_4321, 5'd16, 1'b1, 32'hFFFF_8765);
        run("srl_4",      32'hF0F0_F0F0, 5'd4,  1'b0, 32'h0F0F_0F0F);

        // Second start while busy must be ignored.
        d0 = done_count;
        issue(32'h1234_5678, 5'd4, 1'b0);
        @(posedge clock);
        #1 start = 1'b1;
        din   = 32'hFFFF_FFFF;
        shamt = 5'd4;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(lat);
        check("busy_ignore_out", dout, 32'h0123_4567);
        repeat (10) @(posedge clock);
        #1;
        check("busy_ignore_one_done", 32'(done_count - d0), 32'd1);

        // Reset after E3 aborts the operation.
        d0 = done_count;
        issue(32'hDEAD_BEEF, 5'd13, 1'b1);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_out",  dout,      32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("abort_no_done", 32'(done_count - d0), 32'd0);
        run("after_reset", 32'h0000_FF00, 5'd8, 1'b0, 32'h0000_00FF);

        // Back-to-back: new request presented during the DONE cycle.
        issue(32'h8000_0000, 5'd1, 1'b1);
        wait_done(lat);
        c1 = cycle;
        check("b2b_first", dout, 32'hC000_0000);
        start = 1'b1;
        din   = 32'h0000_0F0F;
        shamt = 5'd3;
        arith = 1'b0;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(lat);
        c2 = cycle;
        check("b2b_second", dout, 32'h0000_01E1);
        check("b2b_spacing", 32'(c2 - c1), 32'd6);

        repeat (3) @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
